spi_send_engine: RTL and testbench
==================================

// Module: spi_send_engine
// PURPOSE
//  SPI master transmit engine (mode 0, MSB first) driving the send side of the SPI bus arbiter.
//  Accepts bytes over a valid/ready stream and frames them under one CS.
//  Produces send_spi_sclk, send_spi_cs and spi_mosi, and requests bus ownership through mutex.
//  Never claims the bus while the read engine owns it (bus_busy).
// PARAMETERS
//  CLK_DIV   4  clk cycles per SCLK half-period (>=1)
//  DATA_W    8  bits per transfer word
//  CS_SETUP  2  clk cycles from CS low to first SCLK low phase (>=1)
//  CS_HOLD   2  clk cycles from last SCLK falling edge to CS high (>=1)
// PORTS
//  clk            in   1       system clock, all logic on posedge
//  rst            in   1       asynchronous reset, active-low
//  tx_valid       in   1       tx_data/tx_last valid
//  tx_data        in   DATA_W  word to send, MSB first
//  tx_last        in   1       word is last of frame; CS released after it
//  tx_ready       out  1       handshake accept when tx_valid&&tx_ready
//  bus_busy       in   1       read engine owns the bus (its omutex)
//  mutex          out  1       send engine owns the bus
//  send_spi_sclk  out  1       SPI clock, idle 0
//  send_spi_cs    out  1       chip select, active-low, idle 1
//  spi_mosi       out  1       serial data, idle 1
//  done           out  1       one-cycle pulse when frame completes
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; mutex=0, send_spi_sclk=0, send_spi_cs=1, spi_mosi=1,
//   done=0, tx_ready=0 while reset is held; counters cleared. Mid-frame reset aborts immediately, no CS hold.
//  All outputs are registered except tx_ready = (IDLE && !bus_busy) || NEXT.
//  States: IDLE, SETUP, SHIFT, NEXT, HOLD, RELEASE.
//  IDLE: on accept -> load shift reg and last flag; next cycle mutex=1, cs=0, mosi=MSB; go SETUP.
//   bus_busy high blocks acceptance (tx_ready=0); a frame in progress ignores bus_busy.
//  SETUP: CS_SETUP cycles, sclk=0; then SHIFT.
//  SHIFT: per bit CLK_DIV cycles sclk=0 then CLK_DIV cycles sclk=1; mosi updates at
//   start of each low phase (held stable across rising edge). One word = 2*CLK_DIV*DATA_W cycles.
//   After high phase of bit 0: last flag ? HOLD : NEXT (sclk returns 0).
//  NEXT: sclk=0, cs=0, mosi holds last bit; waits indefinitely for tx_valid; on accept
//   load word, mosi=new MSB next cycle, go SHIFT (no setup delay). tx_last captured per word.
//  HOLD: CS_HOLD cycles, sclk=0, cs=0; then cs=1, mosi=1, go RELEASE.
//  RELEASE: one cycle, cs=1, mutex still 1, done=1; then IDLE with mutex=0.
//  mutex is high from the cycle after IDLE accept through RELEASE inclusive, so CS edges
//   are always inside bus ownership.
//  Counters: half-period counter $clog2(CLK_DIV)+1 bits, bit counter $clog2(DATA_W)+1 bits;
//   both wrap to 0 on phase/word completion; no overflow possible.
//  tx_data/tx_last ignored unless handshake occurs; tx_valid while busy is held off (tx_ready=0).
// TESTING (CLK_DIV=2, DATA_W=8, CS_SETUP=2, CS_HOLD=2 unless noted)
//  1. Single 0xA5, tx_last=1, accept at cycle 0 -> cs low cycles 1..36, 8 rising sclk edges
//     sampling mosi 1,0,1,0,0,1,0,1; cs high + done at cycle 37; mutex 1 cycles 1..37, 0 at 38.
//  2. Frame 0x3C,0xFF (second tx_last=1) offered back-to-back -> 16 rising edges,
//     cs stays low throughout, bits 00111100 11111111, single done pulse.
//  3. bus_busy=1 with tx_valid=1 for 10 cycles -> tx_ready=0, mutex=0, cs=1; bus_busy drops
//     -> accept same cycle, frame proceeds as test 1.
//  4. Gap: tx_valid low for 20 cycles in NEXT -> sclk=0, cs=0, mutex=1 held; resumes on valid.
//  5. rst low mid-word (cycle 15 of test 1) -> same cycle cs=1, sclk=0, mosi=1, mutex=0,
//     no done; after release next frame transmits normally.
//  6. CLK_DIV=1, 0x80 tx_last=1 -> sclk toggles every cycle, 8 rising edges, mosi 1 then seven 0.

Source files
------------

// File: rtl/spi_send_engine.sv
`timescale 1ns/1ps
// spi_send_engine: SPI master transmit engine (mode 0, MSB first).
// Frames a stream of words under one chip select and owns the shared SPI
// bus (mutex) for the whole frame; never claims the bus while bus_busy.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   tx_valid/tx_data/tx_last/tx_ready   word stream in (tx_ready combinational)
//   bus_busy        read engine owns the bus
//   mutex           this engine owns the bus
//   send_spi_sclk, send_spi_cs, spi_mosi   SPI pins
//   done            one-cycle pulse at frame completion
module spi_send_engine #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_last,
  output logic              tx_ready,
  input  logic              bus_busy,
  output logic              mutex,
  output logic              send_spi_sclk,
  output logic              send_spi_cs,
  output logic              spi_mosi,
  output logic              done
);

  localparam int unsigned HALF_W  = $clog2(CLK_DIV) + 1;
  localparam int unsigned BIT_W   = $clog2(DATA_W) + 1;
  localparam int unsigned DLY_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_NEXT,
    S_HOLD,
    S_RELEASE
  } state_t;

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   half_q, half_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic                last_q, last_d;
  logic                mutex_q, mutex_d;
  logic                sclk_q, sclk_d;
  logic                cs_q, cs_d;
  logic                mosi_q, mosi_d;
  logic                done_q, done_d;
  logic                accept_c;

  // Ready only in IDLE (when the bus is free) or between words of a frame.
  assign tx_ready = rst && (((state_q == S_IDLE) && !bus_busy) || (state_q == S_NEXT));
  assign accept_c = tx_valid && tx_ready;

  assign mutex         = mutex_q;
  assign send_spi_sclk = sclk_q;
  assign send_spi_cs   = cs_q;
  assign spi_mosi      = mosi_q;
  assign done          = done_q;

  // State and output registers; reset aborts a frame with no CS hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      half_q  <= '0;
      bit_q   <= '0;
      dly_q   <= '0;
      sreg_q  <= '0;
      last_q  <= 1'b0;
      mutex_q <= 1'b0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      dly_q   <= dly_d;
      sreg_q  <= sreg_d;
      last_q  <= last_d;
      mutex_q <= mutex_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    bit_d   = bit_q;
    dly_d   = dly_q;
    sreg_d  = sreg_q;
    last_d  = last_q;
    mutex_d = mutex_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          sreg_d  = tx_data;
          last_d  = tx_last;
          mutex_d = 1'b1;
          cs_d    = 1'b0;
          mosi_d  = tx_data[DATA_W-1];
          dly_d   = '0;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (dly_q == DLY_W'(CS_SETUP - 1)) begin
          dly_d   = '0;
          half_d  = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          state_d = S_SHIFT;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      // Low phase then high phase per bit; mosi advances only when a new
      // low phase starts, so it is stable around the rising edge.
      S_SHIFT: begin
        if (half_q == HALF_W'(CLK_DIV - 1)) begin
          half_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(DATA_W - 1)) begin
              bit_d   = '0;
              dly_d   = '0;
              state_d = last_q ? S_HOLD : S_NEXT;
            end else begin
              bit_d  = bit_q + BIT_W'(1);
              sreg_d = sreg_q << 1;
              mosi_d = sreg_d[DATA_W-1];
            end
          end
        end else begin
          half_d = half_q + HALF_W'(1);
        end
      end

      // Between words: CS stays low and mosi keeps the last bit.
      S_NEXT: begin
        if (accept_c) begin
          sreg_d  = tx_data;
          last_d  = tx_last;
          mosi_d  = tx_data[DATA_W-1];
          half_d  = '0;
          bit_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_HOLD: begin
        if (dly_q == DLY_W'(CS_HOLD - 1)) begin
          cs_d    = 1'b1;
          mosi_d  = 1'b1;
          done_d  = 1'b1;
          state_d = S_RELEASE;
        end else begin
          dly_d = dly_q + DLY_W'(1);
        end
      end

      // CS already high; keep the bus one more cycle so CS rises inside ownership.
      S_RELEASE: begin
        mutex_d = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_send_engine.sv
`timescale 1ns/1ps
// Bench for spi_send_engine: two instances (CLK_DIV=2 and CLK_DIV=1) checked
// every cycle against a timeline model, plus literal checks on directed frames.
module tb_spi_send_engine;

  localparam int W     = 8;
  localparam int SETUP = 2;
  localparam int HOLD  = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       tx_valid[2];
  logic [7:0] tx_data[2];
  logic       tx_last[2];
  logic       bus_busy[2];
  logic       tx_ready[2], mutex[2], sclk[2], cs[2], mosi[2], done[2];

  logic busy_force[2];
  logic rnd_bit[2];
  logic rnd_busy = 1'b0;
  assign bus_busy[0] = busy_force[0] | (rnd_busy & rnd_bit[0]);
  assign bus_busy[1] = busy_force[1] | (rnd_busy & rnd_bit[1]);

  spi_send_engine #(.CLK_DIV(2), .DATA_W(8), .CS_SETUP(2), .CS_HOLD(2)) u_dut0 (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_last(tx_last[0]), .tx_ready(tx_ready[0]),
    .bus_busy(bus_busy[0]), .mutex(mutex[0]),
    .send_spi_sclk(sclk[0]), .send_spi_cs(cs[0]), .spi_mosi(mosi[0]), .done(done[0])
  );

  spi_send_engine #(.CLK_DIV(1), .DATA_W(8), .CS_SETUP(2), .CS_HOLD(2)) u_dut1 (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_last(tx_last[1]), .tx_ready(tx_ready[1]),
    .bus_busy(bus_busy[1]), .mutex(mutex[1]),
    .send_spi_sclk(sclk[1]), .send_spi_cs(cs[1]), .spi_mosi(mosi[1]), .done(done[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- timeline model ----------------
  // A frame is described by the cycle its current word starts shifting (m_ws);
  // everything else follows arithmetically from the offset into that word.
  bit         m_act[2]  = '{1'b0, 1'b0};
  int         m_ws[2]   = '{0, 0};
  logic [7:0] m_word[2] = '{8'h00, 8'h00};
  bit         m_last[2] = '{1'b0, 1'b0};

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Returns {tx_ready, mutex, cs, sclk, mosi, done} for cycle c.
  function automatic logic [5:0] model_exp(input int i, input int c);
    int d, k, p;
    logic [7:0] w;
    d = dv(i);
    p = 2 * d * W;
    w = m_word[i];
    if (!rst) return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    if (!m_act[i]) return {!bus_busy[i], 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    if (c < m_ws[i]) return {1'b0, 1'b1, 1'b0, 1'b0, w[7], 1'b0};
    k = c - m_ws[i];
    if (k < p) return {1'b0, 1'b1, 1'b0, 1'((k % (2 * d)) >= d), w[7 - k / (2 * d)], 1'b0};
    if (!m_last[i]) return {1'b1, 1'b1, 1'b0, 1'b0, w[0], 1'b0};
    if (k - p < HOLD) return {1'b0, 1'b1, 1'b0, 1'b0, w[0], 1'b0};
    return {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  endfunction

  task automatic model_step(input int i, input int c, input logic rdy);
    int p;
    p = 2 * dv(i) * W;
    if (!rst) m_act[i] = 1'b0;
    else if (m_act[i] && m_last[i] && (c - m_ws[i]) == p + HOLD) m_act[i] = 1'b0;
    else if (tx_valid[i] && rdy) begin
      m_ws[i]   = m_act[i] ? c + 1 : c + 1 + SETUP;
      m_act[i]  = 1'b1;
      m_word[i] = tx_data[i];
      m_last[i] = tx_last[i];
    end
  endtask

  // Per-cycle compare of every output of both instances.
  always @(negedge clk) begin
    logic [5:0] e;
    for (int i = 0; i < 2; i++) begin
      e = model_exp(i, cyc);
      check($sformatf("outputs_dut%0d", i),
            {26'd0, tx_ready[i], mutex[i], cs[i], sclk[i], mosi[i], done[i]}, {26'd0, e});
      model_step(i, cyc, e[5]);
    end
  end

  // ---------------- observation counters for literal checks ----------------
  logic        prev_sclk[2] = '{1'b0, 1'b0};
  logic        prev_cs[2]   = '{1'b1, 1'b1};
  int          edges[2], toggles[2], done_cnt[2], done_cyc[2], cs_low[2], mutex_hi[2], cs_rise[2];
  logic [31:0] cap[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sclk[i] && !prev_sclk[i]) begin
        edges[i]++;
        cap[i] = {cap[i][30:0], mosi[i]};
      end
      if (sclk[i] !== prev_sclk[i]) toggles[i]++;
      if (done[i]) begin
        done_cnt[i]++;
        done_cyc[i] = cyc;
      end
      if (!cs[i]) cs_low[i]++;
      if (mutex[i]) mutex_hi[i]++;
      if (cs[i] && !prev_cs[i]) cs_rise[i]++;
      prev_sclk[i] = sclk[i];
      prev_cs[i]   = cs[i];
    end
  end

  task automatic clear_stats(input int i);
    edges[i] = 0; toggles[i] = 0; done_cnt[i] = 0; done_cyc[i] = -1;
    cs_low[i] = 0; mutex_hi[i] = 0; cs_rise[i] = 0; cap[i] = '0;
  endtask

  always begin
    @(posedge clk);
    #1;
    rnd_bit[0] = ($urandom_range(3, 0) == 0);
    rnd_bit[1] = ($urandom_range(3, 0) == 0);
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic send_word(input int i, input logic [7:0] d, input logic l, output int acc);
    int budget;
    tx_valid[i] = 1'b1;
    tx_data[i]  = d;
    tx_last[i]  = l;
    acc = -1;
    budget = 0;
    while (acc < 0 && budget < 2000) begin
      @(negedge clk);
      if (tx_ready[i]) acc = cyc;
      @(posedge clk);
      #1;
      budget++;
    end
    tx_valid[i] = 1'b0;
    tx_data[i]  = 8'($urandom);
    tx_last[i]  = 1'($urandom);
    if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int i);
    int b;
    b = 0;
    while (m_act[i] && b < 3000) begin
      @(posedge clk);
      #1;
      b++;
    end
    if (m_act[i]) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a, a2, bc, i, nw;
    logic [7:0] w;
    for (int j = 0; j < 2; j++) begin
      tx_valid[j] = 1'b0; tx_data[j] = 8'h00; tx_last[j] = 1'b0;
      busy_force[j] = 1'b0; rnd_bit[j] = 1'b0;
      clear_stats(j);
    end

    // Reset held: idle outputs.
    idle_cycles(3);
    @(negedge clk);
    check("reset_outputs", {26'd0, tx_ready[0], mutex[0], cs[0], sclk[0], mosi[0], done[0]}, 32'b001010);
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_cycles(2);

    // Single 0xA5 frame.
    clear_stats(0);
    send_word(0, 8'hA5, 1'b1, a);
    wait_idle(0);
    check("t1_done_latency", 32'(done_cyc[0] - a), 32'd37);
    check("t1_cs_low_cycles", 32'(cs_low[0]), 32'd36);
    check("t1_mutex_cycles", 32'(mutex_hi[0]), 32'd37);
    check("t1_rising_edges", 32'(edges[0]), 32'd8);
    check("t1_bits", cap[0], 32'h0000_00A5);
    check("t1_done_pulses", 32'(done_cnt[0]), 32'd1);

    // Back-to-back two-word frame.
    idle_cycles(2);
    clear_stats(0);
    send_word(0, 8'h3C, 1'b0, a);
    send_word(0, 8'hFF, 1'b1, a2);
    wait_idle(0);
    check("t2_second_accept", 32'(a2 - a), 32'd35);
    check("t2_rising_edges", 32'(edges[0]), 32'd16);
    check("t2_bits", cap[0], 32'h0000_3CFF);
    check("t2_done_pulses", 32'(done_cnt[0]), 32'd1);
    check("t2_cs_rises", 32'(cs_rise[0]), 32'd1);

    // Bus busy holds off acceptance.
    idle_cycles(2);
    busy_force[0] = 1'b1;
    tx_valid[0] = 1'b1; tx_data[0] = 8'hA5; tx_last[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_busy_holdoff", {29'd0, tx_ready[0], mutex[0], cs[0]}, 32'b001);
      @(posedge clk);
      #1;
    end
    busy_force[0] = 1'b0;
    bc = cyc;
    clear_stats(0);
    send_word(0, 8'hA5, 1'b1, a);
    wait_idle(0);
    check("t3_accept_cycle", 32'(a - bc), 32'd0);
    check("t3_done_latency", 32'(done_cyc[0] - a), 32'd37);
    check("t3_bits", cap[0], 32'h0000_00A5);

    // 20-cycle gap in NEXT.
    idle_cycles(2);
    clear_stats(0);
    send_word(0, 8'h5A, 1'b0, a);
    idle_cycles(49);
    @(negedge clk);
    check("t4_gap_hold", {29'd0, sclk[0], cs[0], mutex[0]}, 32'b001);
    repeat (5) @(posedge clk);
    #1;
    send_word(0, 8'hC3, 1'b1, a2);
    wait_idle(0);
    check("t4_resume_accept", 32'(a2 - a), 32'd55);
    check("t4_rising_edges", 32'(edges[0]), 32'd16);
    check("t4_bits", cap[0], 32'h0000_5AC3);
    check("t4_done_pulses", 32'(done_cnt[0]), 32'd1);

    // Reset in the middle of a word.
    idle_cycles(2);
    clear_stats(0);
    send_word(0, 8'hA5, 1'b1, a);
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("t5_reset_abort", {26'd0, tx_ready[0], mutex[0], cs[0], sclk[0], mosi[0], done[0]}, 32'b001010);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    idle_cycles(3);
    check("t5_no_done", 32'(done_cnt[0]), 32'd0);
    clear_stats(0);
    send_word(0, 8'hA5, 1'b1, a);
    wait_idle(0);
    check("t5_after_done_latency", 32'(done_cyc[0] - a), 32'd37);
    check("t5_after_bits", cap[0], 32'h0000_00A5);

    // CLK_DIV=1 instance.
    clear_stats(1);
    send_word(1, 8'h80, 1'b1, a);
    wait_idle(1);
    check("t6_rising_edges", 32'(edges[1]), 32'd8);
    check("t6_bits", cap[1], 32'h0000_0080);
    check("t6_sclk_toggles", 32'(toggles[1]), 32'd16);
    check("t6_done_latency", 32'(done_cyc[1] - a), 32'd21);

    // Random frames with random bus_busy on both instances.
    rnd_busy = 1'b1;
    for (int f = 0; f < 40; f++) begin
      i  = $urandom_range(1, 0);
      nw = $urandom_range(3, 1);
      idle_cycles($urandom_range(4, 0));
      for (int k = 0; k < nw; k++) begin
        w = 8'($urandom);
        send_word(i, w, 1'(k == nw - 1), a);
        if (k != nw - 1) idle_cycles(($urandom_range(3, 0) == 0) ? $urandom_range(60, 0) : 0);
      end
      wait_idle(i);
    end
    rnd_busy = 1'b0;
    idle_cycles(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
